// File: rtl/io_arbiter.sv
// io_arbiter: merges NCH valid/ready input channels onto one registered
// output channel. Arbitration is round-robin or fixed priority, chosen at
// runtime by prio_mode. The output word is held until the sink accepts it,
// so no data is lost under backpressure. Each word is tagged with the
// index of the channel it came from.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_data    NCH*WIDTH input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel word available
//   in_ready   per-channel word accepted this cycle (with in_valid)
//   prio_mode  0 = round-robin, 1 = fixed priority (lowest index wins)
//   out_data   registered selected word
//   out_chan   source channel of out_data
//   out_valid  out_data/out_chan valid
//   out_ready  sink accepts the word when out_valid is also high
//   xfer_cnt   count of completed output transfers, wraps
module io_arbiter #(
    parameter int NCH   = 3,
    parameter int WIDTH = 16,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 prio_mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);

    logic [CW-1:0]    rr_ptr;
    logic             slot_free;
    logic             gany;
    logic [CW-1:0]    gidx;
    logic [NCH-1:0]   grant;
    logic [WIDTH-1:0] sel_data;
    logic             accept;
    logic             out_xfer;

    assign slot_free = !out_valid || out_ready;

    // Round-robin search split into two passes over constant indices:
    // first the channels above rr_ptr, then wrap to the lowest valid one.
    // Priority mode skips the first pass, leaving a plain lowest-index pick.
    always_comb begin
        gany = 1'b0;
        gidx = '0;
        if (!prio_mode) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!gany && in_valid[i] && (CW'(i) > rr_ptr)) begin
                    gany = 1'b1;
                    gidx = CW'(i);
                end
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!gany && in_valid[i]) begin
                gany = 1'b1;
                gidx = CW'(i);
            end
        end
    end

    // Only the granted channel's slice is read, so X on idle channels
    // cannot reach out_data.
    always_comb begin
        grant    = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gany && (gidx == CW'(i))) begin
                grant[i] = 1'b1;
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = grant & {NCH{slot_free}};
    assign accept   = gany && slot_free;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            xfer_cnt  <= '0;
            rr_ptr    <= CW'(NCH - 1);
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= gidx;
                if (!prio_mode) begin
                    rr_ptr <= gidx;
                end
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
            if (out_xfer) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed testbench for io_arbiter (NCH=3, WIDTH=16, CW=3).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, away from the rising active edge.
module tb_io_arbiter;

    localparam int NCH   = 3;
    localparam int WIDTH = 16;
    localparam int CW    = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 prio_mode;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_chan;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          xfer_cnt;

    int checks;
    int errors;

    logic [WIDTH-1:0] chdata [NCH];

    io_arbiter #(
        .NCH   (NCH),
        .WIDTH (WIDTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prio_mode (prio_mode),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_data();
        chdata[0] = 16'h1111;
        chdata[1] = 16'h2222;
        chdata[2] = 16'h3333;
        in_data   = {chdata[2], chdata[1], chdata[0]};
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        prio_mode = 1'b0;
        load_data();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_data got %h want 0000", out_data);
        end
        checks++;
        if (out_chan !== 3'd0) begin
            errors++;
            $display("FAIL reset_out_chan got %0d want 0", out_chan);
        end
        checks++;
        if (xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_xfer_cnt got %h want 0000", xfer_cnt);
        end
        checks++;
        if (in_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 000", in_ready);
        end

        // Park a word on the output under backpressure, then reset mid-cycle.
        in_valid  = 3'b100;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_chan !== 3'd2) begin
            errors++;
            $display("FAIL pending_word got v=%b d=%h c=%0d want v=1 d=3333 c=2",
                     out_valid, out_data, out_chan);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 ||
            out_chan !== 3'd0 || xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h c=%0d x=%h want all zero",
                     out_valid, out_data, out_chan, xfer_cnt);
        end
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_fairness();
        do_reset();
        in_valid  = 3'b111;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_chan !== CW'(c % 3) ||
                out_data !== chdata[c % 3]) begin
                errors++;
                $display("FAIL rr_seq[%0d] got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         c, out_valid, out_chan, out_data, c % 3, chdata[c % 3]);
            end
        end
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'd6) begin
            errors++;
            $display("FAIL rr_xfer_cnt got %0d want 6", xfer_cnt);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_priority();
        do_reset();
        prio_mode = 1'b1;
        out_ready = 1'b1;
        in_valid  = 3'b110;
        // Idle channel 0 carries X; it must never leak to out_data.
        in_data[15:0] = 'x;
        #1;
        checks++;
        if (in_ready !== 3'b010) begin
            errors++;
            $display("FAIL prio_in_ready got %b want 010", in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_chan !== 3'd1 || out_data !== 16'h2222) begin
                errors++;
                $display("FAIL prio_ch1[%0d] got v=%b c=%0d d=%h want v=1 c=1 d=2222",
                         c, out_valid, out_chan, out_data);
            end
        end
        in_valid = 3'b100;
        @(negedge clk);
        checks++;
        if (out_chan !== 3'd2 || out_data !== 16'h3333) begin
            errors++;
            $display("FAIL prio_ch2 got c=%0d d=%h want c=2 d=3333", out_chan, out_data);
        end
        load_data();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 3'b010;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_chan !== 3'd1 ||
                in_ready !== 3'b000 || xfer_cnt !== 16'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d rdy=%b x=%0d want v=1 d=2222 c=1 rdy=000 x=0",
                         c, out_valid, out_data, out_chan, in_ready, xfer_cnt);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 3'b100) begin
            errors++;
            $display("FAIL bp_release_ready got %b want 100", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 3'd2 || out_data !== 16'h3333 ||
            xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_release got v=%b c=%0d d=%h x=%0d want v=1 c=2 d=3333 x=1",
                     out_valid, out_chan, out_data, xfer_cnt);
        end
    endtask

    task automatic test_sparse_rr();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b100;
        @(negedge clk);
        checks++;
        if (out_chan !== 3'd2 || out_data !== 16'h3333) begin
            errors++;
            $display("FAIL sparse_ch2 got c=%0d d=%h want c=2 d=3333", out_chan, out_data);
        end
        in_valid = 3'b101;
        @(negedge clk);
        checks++;
        if (out_chan !== 3'd0 || out_data !== 16'h1111) begin
            errors++;
            $display("FAIL sparse_wrap got c=%0d d=%h want c=0 d=1111", out_chan, out_data);
        end
    endtask

    task automatic test_wrap();
        int glitches;
        glitches = 0;
        do_reset();
        in_valid  = 3'b111;
        out_ready = 1'b1;
        // After cycle n the counter holds n-1 completed transfers.
        for (int n = 1; n <= 65537; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b1) glitches++;
            if (n == 65536) begin
                checks++;
                if (xfer_cnt !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL wrap_ffff got %h want ffff", xfer_cnt);
                end
            end
        end
        checks++;
        if (xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero got %h want 0000", xfer_cnt);
        end
        checks++;
        if (glitches !== 0) begin
            errors++;
            $display("FAIL wrap_out_valid got %0d drops want 0", glitches);
        end
        in_valid = '0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        prio_mode = 1'b0;
        load_data();
        test_reset();
        test_rr_fairness();
        test_priority();
        test_backpressure();
        test_sparse_rr();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
